// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Writeback stage sitting directly in front of the register file and the
//   only driver of its write port (a3/we3/wd3). Two result sources share the
//   port:
//     - ALU results, offered with a valid/ready handshake.
//     - Load returns from data memory, which cannot be stalled.
//   Loads always win. An ALU result that collides with a load is parked in a
//   one-entry skid register and written on the first cycle without a load.
//   Sub-word loads are byte/halfword selected and sign/zero extended here, and
//   writes to x0 are dropped (the source is still consumed).
//
//   Optional feature: define WB_STATS_EN to add the stat_writes_o and
//   stat_stalls_o counters.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        synchronous active-high reset
//   alu_valid_i  ALU result offered
//   alu_ready_o  ALU result accepted when alu_valid_i & alu_ready_o
//   alu_rd_i     ALU destination register
//   alu_data_i   ALU result
//   ld_valid_i   load return this cycle, always accepted
//   ld_rd_i      load destination register
//   ld_funct3_i  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU (others illegal)
//   ld_offset_i  load address bits [1:0]
//   ld_rdata_i   raw aligned memory word
//   ld_err_o     one-cycle pulse after an illegal funct3 load
//   rf_we3_o     register file write enable (registered)
//   rf_a3_o      register file write address (registered)
//   rf_wd3_o     register file write data (registered)
//   dbg_state_o  skid state (0 EMPTY, 1 HELD) for observation
//   stat_writes_o / stat_stalls_o  (WB_STATS_EN only) event counters
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int XLen = 32,
   parameter int NReg = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    alu_valid_i,
   output logic                    alu_ready_o,
   input  logic [$clog2(NReg)-1:0] alu_rd_i,
   input  logic [XLen-1:0]         alu_data_i,
   input  logic                    ld_valid_i,
   input  logic [$clog2(NReg)-1:0] ld_rd_i,
   input  logic [2:0]              ld_funct3_i,
   input  logic [1:0]              ld_offset_i,
   input  logic [XLen-1:0]         ld_rdata_i,
   output logic                    ld_err_o,
   output logic                    rf_we3_o,
   output logic [$clog2(NReg)-1:0] rf_a3_o,
   output logic [XLen-1:0]         rf_wd3_o,
`ifdef WB_STATS_EN
   output logic [31:0]             stat_writes_o,
   output logic [31:0]             stat_stalls_o,
`endif
   output logic                    dbg_state_o
);

   localparam int NRegWidth = $clog2(NReg);

   typedef enum logic {
      EMPTY = 1'b0,
      HELD  = 1'b1
   } skid_state_e;

   skid_state_e          state_q, state_d;
   logic [NRegWidth-1:0] skid_rd_q;
   logic [XLen-1:0]      skid_data_q;

   logic                 alu_fire;
   logic                 skid_load;
   logic                 ld_legal;
   logic [XLen-1:0]      ld_ext;
   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;

   logic                 sel_valid;
   logic [NRegWidth-1:0] sel_rd;
   logic [XLen-1:0]      sel_data;
   logic                 we_d;
   logic                 err_d;

   // Handshake: an ALU result transfers on a rising edge where both
   // alu_valid_i and alu_ready_o are high. alu_ready_o depends only on the
   // skid state and reset, never on ld_valid_i, so the producer sees a
   // stable ready for the whole cycle.
   assign alu_ready_o = (state_q == EMPTY) & ~rst_i;
   assign alu_fire    = alu_valid_i & alu_ready_o;
   assign dbg_state_o = (state_q == HELD);

   // Load data extraction. Halfwords use only offset bit 1; LW ignores offset.
   always_comb begin
      ld_byte  = ld_rdata_i[8*ld_offset_i +: 8];
      ld_half  = ld_offset_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
      ld_legal = 1'b1;
      ld_ext   = ld_rdata_i;
      unique case (ld_funct3_i)
         3'd0:    ld_ext = {{(XLen-8){ld_byte[7]}}, ld_byte};
         3'd1:    ld_ext = {{(XLen-16){ld_half[15]}}, ld_half};
         3'd2:    ld_ext = ld_rdata_i;
         3'd4:    ld_ext = {{(XLen-8){1'b0}}, ld_byte};
         3'd5:    ld_ext = {{(XLen-16){1'b0}}, ld_half};
         default: ld_legal = 1'b0;
      endcase
   end

   // Port selection by priority: load, then skid, then direct ALU.
   always_comb begin
      state_d   = state_q;
      skid_load = 1'b0;
      sel_valid = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      err_d     = 1'b0;
      if (ld_valid_i) begin
         // An illegal load still claims the port, so a colliding ALU result
         // is parked exactly as for a legal one.
         sel_valid = ld_legal;
         sel_rd    = ld_rd_i;
         sel_data  = ld_ext;
         err_d     = ~ld_legal;
         if (alu_fire) begin
            skid_load = 1'b1;
            state_d   = HELD;
         end
      end else if (state_q == HELD) begin
         sel_valid = 1'b1;
         sel_rd    = skid_rd_q;
         sel_data  = skid_data_q;
         state_d   = EMPTY;
      end else if (alu_fire) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd_i;
         sel_data  = alu_data_i;
      end
      // x0 writes are dropped but the source was still consumed above.
      we_d = sel_valid & (sel_rd != '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= EMPTY;
         skid_rd_q   <= '0;
         skid_data_q <= '0;
         rf_we3_o    <= 1'b0;
         rf_a3_o     <= '0;
         rf_wd3_o    <= '0;
         ld_err_o    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rf_we3_o <= we_d;
         ld_err_o <= err_d;
         if (skid_load) begin
            skid_rd_q   <= alu_rd_i;
            skid_data_q <= alu_data_i;
         end
         // Address/data hold their last written values when nothing is written.
         if (we_d) begin
            rf_a3_o  <= sel_rd;
            rf_wd3_o <= sel_data;
         end
      end
   end

`ifdef WB_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_writes_o <= '0;
         stat_stalls_o <= '0;
      end else begin
         if (rf_we3_o) stat_writes_o <= stat_writes_o + 32'd1;
         if (alu_valid_i & ~alu_ready_o) stat_stalls_o <= stat_stalls_o + 32'd1;
      end
   end
`endif

endmodule
